// File: rtl/sdram_burst_loader_if.sv
// rtl/sdram_burst_loader_if.sv - word stream and SDRAM controller bus bundle
// Purpose: groups the incoming word stream handshake and the SDRAM controller
// request/ack bus used by sdram_burst_loader.
// Signals:
//   in_valid/in_ready/in_data            word stream from the I2C slave
//   write_req/write_address/write_data   line write request to the controller
//   write_ack                            controller accepted the write
//   read_req/read_address                line read request to the controller
//   read_data/read_ack                   returned line and its strobe
// Modports: master = loader side, slave = stream source / controller side.
interface sdram_burst_loader_if #(
    parameter int WORD_W = 32,
    parameter int WPL    = 4,
    parameter int ADDR_W = 22
);
    logic                    in_valid;
    logic                    in_ready;
    logic [WORD_W-1:0]       in_data;
    logic                    write_req;
    logic [ADDR_W-1:0]       write_address;
    logic [WORD_W*WPL-1:0]   write_data;
    logic                    write_ack;
    logic                    read_req;
    logic [ADDR_W-1:0]       read_address;
    logic [WORD_W*WPL-1:0]   read_data;
    logic                    read_ack;

    modport master (
        input  in_valid, in_data, write_ack, read_data, read_ack,
        output in_ready, write_req, write_address, write_data,
               read_req, read_address
    );

    modport slave (
        output in_valid, in_data, write_ack, read_data, read_ack,
        input  in_ready, write_req, write_address, write_data,
               read_req, read_address
    );
endinterface

// File: rtl/sdram_burst_loader.sv
// rtl/sdram_burst_loader.sv - packs words into SDRAM lines, writes, verifies, reads back
// Purpose: collects WPL words into one line, writes it to a circular SDRAM
// region starting at BASE_ADDR, optionally reads it back to verify, and serves
// single-line host reads. Every request is bounded by a TIMEOUT-cycle watchdog.
// Ports:
//   MAX10_CLK1_50  clock
//   RESET_N        asynchronous active-low reset
//   bus            word stream + SDRAM controller bus (master modport)
//   flush          pulse: write the partially filled line (zero padded)
//   rd_start/rd_addr   host read request and line address
//   rd_data/rd_done    host read result and completion pulse
//   wr_done        pulse per completed line write
//   line_count     completed line writes, saturating
//   wrapped/verify_err/timeout_err   sticky status flags
module sdram_burst_loader #(
    parameter int WORD_W    = 32,
    parameter int WPL       = 4,
    parameter int ADDR_W    = 22,
    parameter int BASE_ADDR = 1,
    parameter int DEPTH     = 1024,
    parameter int VERIFY    = 1,
    parameter int TIMEOUT   = 1023
) (
    input  logic                    MAX10_CLK1_50,
    input  logic                    RESET_N,
    sdram_burst_loader_if.master    bus,
    input  logic                    flush,
    input  logic                    rd_start,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [WORD_W*WPL-1:0]   rd_data,
    output logic                    rd_done,
    output logic                    wr_done,
    output logic [15:0]             line_count,
    output logic                    wrapped,
    output logic                    verify_err,
    output logic                    timeout_err
);
    localparam int LINE_W = WORD_W * WPL;
    localparam int IDX_W  = $clog2(WPL + 1);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] FIRST    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(BASE_ADDR + DEPTH - 1);
    localparam logic [IDX_W-1:0]  FULL     = IDX_W'(WPL);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WRITE, VRD, RD, DONE} state_t;
    state_t state, state_nxt;

    logic [IDX_W-1:0]  word_idx, idx_after;
    logic [LINE_W-1:0] line_buf;
    logic [ADDR_W-1:0] line_addr, vrd_addr, rd_addr_q;
    logic [CNT_W-1:0]  cnt;
    logic              armed, rd_pending;
    logic              accept, write_due, busy, timed_out;
    logic              write_hit, vrd_hit, rd_hit;

    assign busy      = (state == WRITE) || (state == VRD) || (state == RD);
    assign write_hit = (state == WRITE) && bus.write_ack;
    assign vrd_hit   = (state == VRD) && bus.read_ack;
    assign rd_hit    = (state == RD) && bus.read_ack;

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        bus.in_ready      = 1'b0;
        bus.write_req     = 1'b0;
        bus.write_address = '0;
        bus.write_data    = '0;
        bus.read_req      = 1'b0;
        bus.read_address  = '0;
        accept            = 1'b0;
        idx_after         = word_idx;
        write_due         = 1'b0;
        timed_out         = 1'b0;
        case (state)
            IDLE: begin
                // armed holds in_ready low until the first edge after reset
                bus.in_ready = armed && (word_idx < FULL);
                accept       = bus.in_ready && bus.in_valid;
                idx_after    = word_idx + IDX_W'(accept);
                // a flush in the same cycle as a word counts that word
                write_due    = (idx_after == FULL) || (flush && (idx_after != '0));
                if (write_due)
                    state_nxt = WRITE;
                else if (rd_start || rd_pending)
                    state_nxt = RD;
            end
            WRITE: begin
                bus.write_req     = 1'b1;
                bus.write_address = line_addr;
                bus.write_data    = line_buf;
                if (bus.write_ack)
                    state_nxt = (VERIFY != 0) ? VRD : IDLE;
                else if (cnt == CNT_LAST) begin
                    timed_out = 1'b1;
                    state_nxt = IDLE;
                end
            end
            VRD: begin
                bus.read_req     = 1'b1;
                bus.read_address = vrd_addr;
                if (bus.read_ack)
                    state_nxt = IDLE;
                else if (cnt == CNT_LAST) begin
                    timed_out = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RD: begin
                bus.read_req     = 1'b1;
                bus.read_address = rd_addr_q;
                if (bus.read_ack)
                    state_nxt = DONE;
                else if (cnt == CNT_LAST) begin
                    timed_out = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            armed       <= 1'b0;
            word_idx    <= '0;
            line_buf    <= '0;
            line_addr   <= FIRST;
            vrd_addr    <= '0;
            rd_addr_q   <= '0;
            rd_pending  <= 1'b0;
            cnt         <= '0;
            rd_data     <= '0;
            rd_done     <= 1'b0;
            wr_done     <= 1'b0;
            line_count  <= '0;
            wrapped     <= 1'b0;
            verify_err  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            armed   <= 1'b1;
            wr_done <= write_hit;
            rd_done <= rd_hit;
            cnt     <= (busy && (state_nxt == state)) ? cnt + CNT_W'(1) : '0;

            // the read address stays frozen while its request is outstanding
            if (rd_start && (state != RD))
                rd_addr_q <= rd_addr;
            if ((state == IDLE) && (state_nxt == RD))
                rd_pending <= 1'b0;
            else if (rd_start)
                rd_pending <= 1'b1;

            // slot 0 reloads the whole line so unfilled slots read as zero
            if (accept) begin
                if (word_idx == '0)
                    line_buf <= LINE_W'(bus.in_data);
                for (int i = 1; i < WPL; i++)
                    if (word_idx == IDX_W'(i))
                        line_buf[i*WORD_W +: WORD_W] <= bus.in_data;
                word_idx <= idx_after;
            end

            if (write_hit) begin
                word_idx <= '0;
                vrd_addr <= line_addr;
                if (line_addr == LAST) begin
                    line_addr <= FIRST;
                    wrapped   <= 1'b1;
                end else begin
                    line_addr <= line_addr + ADDR_W'(1);
                end
                if (line_count != 16'hFFFF)
                    line_count <= line_count + 16'd1;
            end

            if (timed_out) begin
                timeout_err <= 1'b1;
                word_idx    <= '0;
            end

            if (vrd_hit && (bus.read_data != line_buf))
                verify_err <= 1'b1;

            if (rd_hit)
                rd_data <= bus.read_data;
        end
    end
endmodule
